// File: rtl/sel_burst_buffer.sv
// Channel-select burst buffer: captures a burst from one of CH input channels
// into a single-port RAM, then replays it forward or reversed over valid/ready.
module sel_burst_buffer #(
  parameter  int DW    = 8,
  parameter  int CH    = 8,
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH),
  localparam int SW    = (CH > 1) ? $clog2(CH) : 1
) (
  input  logic             clk,
  input  logic             rsta,
  input  logic             begin_wr,
  input  logic [SW-1:0]    sel,
  input  logic [AW:0]      len,
  input  logic             rev,
  input  logic [CH*DW-1:0] din,
  output logic [DW-1:0]    dout,
  output logic             out_en,
  input  logic             out_ready,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {IDLE, WR, RD} state_t;

  state_t          state_q, state_d;
  logic [SW-1:0]   sel_q, sel_d;
  logic            rev_q, rev_d;
  logic [AW:0]     len_q, len_d;
  logic [AW-1:0]   wr_cnt_q, wr_cnt_d;
  logic [AW:0]     rd_cnt_q, rd_cnt_d;
  logic            inflight_q, inflight_d;
  logic [1:0]      cnt_q, cnt_d;
  logic [DW-1:0]   q0_q, q0_d, q1_q, q1_d;

  logic [DW-1:0]   mem [DEPTH];
  logic [DW-1:0]   rd_data_q;
  logic [DW-1:0]   chan [CH];

  logic [AW:0]     len_eff;
  logic [SW-1:0]   sel_eff;
  logic [AW-1:0]   rd_addr;
  logic [2:0]      occ;
  logic            wr_en, rd_en, pop, push, last_pop;

  // Unflatten the channel bus so the selected channel is a plain array index.
  for (genvar i = 0; i < CH; i++) begin : g_chan
    assign chan[i] = din[i*DW +: DW];
  end

  // Output queue head and handshake/status decode.
  assign out_en   = (cnt_q != 2'd0);
  assign dout     = q0_q;
  assign busy     = (state_q != IDLE);
  assign pop      = out_en && out_ready;
  assign push     = inflight_q;
  assign wr_en    = (state_q == WR);
  assign last_pop = (state_q == RD) && pop && (rd_cnt_q == len_q) &&
                    !inflight_q && (cnt_q == 2'd1);
  assign done     = last_pop;

  // Read issue: only while words remain and the queue can absorb the return.
  always_comb begin
    occ     = {1'b0, cnt_q} + {2'b00, inflight_q} - {2'b00, pop};
    rd_en   = (state_q == RD) && (rd_cnt_q < len_q) && (occ <= 3'd1);
    rd_addr = rev_q ? AW'(len_q - 1'b1 - rd_cnt_q) : AW'(rd_cnt_q);
  end

  // Normalise the requested length and channel before they are latched.
  always_comb begin
    len_eff = len;
    if (len == '0 || len > (AW+1)'(DEPTH)) len_eff = (AW+1)'(DEPTH);
    sel_eff = sel;
    if ({1'b0, sel} >= (SW+1)'(CH)) sel_eff = SW'(CH - 1);
  end

  // Next-state, counter and output-queue update.
  always_comb begin
    // NOTE: every variable gets its hold value first so no latch is inferred.
    state_d    = state_q;
    sel_d      = sel_q;
    rev_d      = rev_q;
    len_d      = len_q;
    wr_cnt_d   = wr_cnt_q;
    rd_cnt_d   = rd_cnt_q;
    inflight_d = rd_en;
    cnt_d      = cnt_q;
    q0_d       = q0_q;
    q1_d       = q1_q;

    case (state_q)
      IDLE: begin
        if (begin_wr) begin
          sel_d    = sel_eff;
          rev_d    = rev;
          len_d    = len_eff;
          wr_cnt_d = '0;
          state_d  = WR;
        end
      end
      WR: begin
        wr_cnt_d = wr_cnt_q + 1'b1;
        if ({1'b0, wr_cnt_q} == len_q - 1'b1) begin
          rd_cnt_d = '0;
          state_d  = RD;
        end
      end
      RD: begin
        if (rd_en)    rd_cnt_d = rd_cnt_q + 1'b1;
        if (last_pop) state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase

    case ({pop, push})
      2'b10: begin
        q0_d  = q1_q;
        cnt_d = cnt_q - 2'd1;
      end
      2'b01: begin
        if (cnt_q == 2'd0) q0_d = rd_data_q;
        else               q1_d = rd_data_q;
        cnt_d = cnt_q + 2'd1;
      end
      2'b11: begin
        if (cnt_q == 2'd2) begin
          q0_d = q1_q;
          q1_d = rd_data_q;
        end else begin
          q0_d = rd_data_q;
        end
      end
      default: ;
    endcase
  end

  // Control state register; reset aborts any burst and flushes the queue.
  always_ff @(posedge clk or posedge rsta) begin
    if (rsta) begin
      state_q    <= IDLE;
      sel_q      <= '0;
      rev_q      <= 1'b0;
      len_q      <= '0;
      wr_cnt_q   <= '0;
      rd_cnt_q   <= '0;
      inflight_q <= 1'b0;
      cnt_q      <= '0;
      q0_q       <= '0;
      q1_q       <= '0;
    end else begin
      // NOTE: non-blocking so every flop samples values from before the edge.
      state_q    <= state_d;
      sel_q      <= sel_d;
      rev_q      <= rev_d;
      len_q      <= len_d;
      wr_cnt_q   <= wr_cnt_d;
      rd_cnt_q   <= rd_cnt_d;
      inflight_q <= inflight_d;
      cnt_q      <= cnt_d;
      q0_q       <= q0_d;
      q1_q       <= q1_d;
    end
  end

  // Single-port RAM with registered read data.
  // NOTE: RAM has no reset; reads only target words written in this burst.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_cnt_q] <= chan[sel_q];
    if (rd_en) rd_data_q <= mem[rd_addr];
  end

endmodule

// File: tb/tb_sel_burst_buffer.sv
// Randomized scoreboard bench for sel_burst_buffer.
module tb_sel_burst_buffer;
  localparam int DW = 8, CH = 8, DEPTH = 8, AW = 3, SW = 3;

  logic             clk = 1'b0;
  logic             rsta, begin_wr, rev, out_ready;
  logic [SW-1:0]    sel;
  logic [AW:0]      len;
  logic [CH*DW-1:0] din;
  logic [DW-1:0]    dout;
  logic             out_en, busy, done;

  typedef struct {
    logic [DW-1:0] data;
    logic          last;
  } exp_t;
  exp_t exp_q[$];

  int   checks = 0, errors = 0, cyc = 0;
  int   pop_cnt = 0, done_cnt = 0, done_cyc = 0, first_cyc = 0;
  bit   first_seen = 1'b0;
  int   ready_mode = 0, pat_idx = 0;
  logic [6:0] pat = 7'b1011001;  // bit i is out_ready in pattern step i: 1,0,0,1,1,0,1
  logic prev_valid = 1'b0, prev_ready = 1'b0;
  logic [DW-1:0] prev_dout = '0;

  sel_burst_buffer #(.DW(DW), .CH(CH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rsta(rsta), .begin_wr(begin_wr), .sel(sel), .len(len), .rev(rev),
    .din(din), .dout(dout), .out_en(out_en), .out_ready(out_ready),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Downstream ready driver: 0 = always ready, 1 = random, 2 = fixed pattern.
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (ready_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = 1'($urandom_range(0, 1));
        default: begin out_ready = pat[pat_idx % 7]; pat_idx++; end
      endcase
    end
  end

  // Monitor: pops the scoreboard on every transfer, checks stall stability.
  always @(negedge clk) begin
    if (rsta) begin
      prev_valid = 1'b0;
    end else begin
      if (prev_valid && !prev_ready) begin
        check("stall_hold_valid", 32'(out_en), 32'd1);
        check("stall_hold_data", 32'(dout), 32'(prev_dout));
      end
      if (out_en && !first_seen) begin
        first_seen = 1'b1;
        first_cyc  = cyc;
      end
      if (out_en && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_word: got %0h expected no transfer", dout);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("dout", 32'(dout), 32'(e.data));
          check("done_on_transfer", 32'(done), 32'(e.last));
        end
        pop_cnt++;
        if (done) begin
          done_cnt++;
          done_cyc = cyc;
        end
      end else begin
        check("done_without_transfer", 32'(done), 32'd0);
      end
      prev_valid = out_en;
      prev_ready = out_ready;
      prev_dout  = dout;
    end
  end

  // One burst: drive writes, push expected words, wait for done (bounded).
  task automatic run_burst(input logic [SW-1:0] s, input logic [AW:0] ln, input bit rv,
                           input int mode, input int base, input bit noise,
                           input int abort_after);
    int L, start, d0, p0, idx;
    bit finished;
    logic [DW-1:0] words[$];
    L = (ln == 0 || ln > DEPTH) ? DEPTH : int'(ln);
    ready_mode = mode;
    pat_idx = 0;
    sel = s; len = ln; rev = rv; begin_wr = 1'b1;
    @(posedge clk); #1;
    start = cyc; begin_wr = 1'b0; first_seen = 1'b0;
    d0 = done_cnt; p0 = pop_cnt;
    check("busy_after_start", 32'(busy), 32'd1);
    for (int i = 0; i < L; i++) begin
      din = {$urandom, $urandom};
      if (base >= 0) din[s*DW +: DW] = DW'(base + i);
      words.push_back(din[s*DW +: DW]);
      if (noise) begin
        begin_wr = 1'($urandom_range(0, 1));
        sel = s + 1'b1;
      end
      @(posedge clk); #1;
    end
    begin_wr = 1'b0;
    sel = s;
    for (int i = 0; i < L; i++) begin
      idx = rv ? (L - 1 - i) : i;
      exp_q.push_back('{words[idx], (i == L - 1)});
    end
    if (noise) begin
      begin_wr = 1'b1;
      sel = s + 1'b1;
      @(posedge clk); #1;
      begin_wr = 1'b0;
      sel = s;
    end
    finished = 1'b0;
    for (int b = 0; b < 400 && !finished; b++) begin
      if (abort_after > 0 && (pop_cnt - p0) >= abort_after) begin
        rsta = 1'b1;
        #1;
        check("abort_out_en", 32'(out_en), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        exp_q.delete();
        @(posedge clk); #1;
        rsta = 1'b0;
        check("abort_idle_busy", 32'(busy), 32'd0);
        return;
      end
      if (done_cnt != d0) finished = 1'b1;
      else begin
        @(posedge clk); #1;
      end
    end
    if (!finished) begin
      checks++; errors++;
      $display("FAIL burst_timeout: got no done expected done within 400 cycles");
      exp_q.delete();
    end else begin
      check("busy_after_done", 32'(busy), 32'd0);
      check("exp_drained", 32'(exp_q.size()), 32'd0);
      check("pop_count", 32'(pop_cnt - p0), 32'(L));
      if (mode == 0) begin
        check("first_out_latency", 32'(first_cyc - start), 32'(L + 2));
        check("done_latency", 32'(done_cyc - start), 32'(2 * L + 1));
      end
    end
  endtask

  initial begin
    rsta = 1'b1; begin_wr = 1'b0; sel = '0; len = '0; rev = 1'b0; din = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_dout", 32'(dout), 32'd0);
    check("reset_out_en", 32'(out_en), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    rsta = 1'b0;
    @(posedge clk); #1;

    run_burst(3'd3, 4'd8, 1'b0, 0, 'h10, 1'b0, 0);   // forward 0x10..0x17
    run_burst(3'd0, 4'd3, 1'b1, 0, 'hA0, 1'b0, 0);   // reverse, short
    run_burst(3'd5, 4'd4, 1'b0, 2, -1, 1'b0, 0);     // backpressure pattern
    run_burst(3'd1, 4'd0, 1'b0, 0, -1, 1'b0, 0);     // len 0 -> DEPTH
    run_burst(3'd7, 4'd9, 1'b1, 0, -1, 1'b0, 0);     // len 9 -> DEPTH
    run_burst(3'd2, 4'd1, 1'b0, 0, -1, 1'b0, 0);     // single word
    run_burst(3'd2, 4'd5, 1'b0, 0, -1, 1'b1, 0);     // ignored starts
    run_burst(3'd4, 4'd6, 1'b1, 1, -1, 1'b1, 0);     // ignored starts + random ready
    run_burst(3'd5, 4'd8, 1'b0, 0, -1, 1'b0, 2);     // reset after 2 words
    run_burst(3'd6, 4'd5, 1'b0, 0, 'h50, 1'b0, 0);   // fresh burst after reset

    for (int n = 0; n < 20; n++) begin
      run_burst(3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)),
                1'($urandom_range(0, 1)), $urandom_range(0, 2), -1,
                1'($urandom_range(0, 1)), 0);
    end

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
